// File: rtl/eeg_agu_pkg.sv
// Shared definitions for the feature-RAM read address generator: one-hot FSM
// encoding and the default depth of the return-data buffer.
package eeg_agu_pkg;

    typedef enum logic [2:0] {
        AGU_IDLE  = 3'b001,
        AGU_RUN   = 3'b010,
        AGU_DRAIN = 3'b100
    } agu_state_e;

    localparam int AGU_FIFO_DEPTH = 4;

endpackage

// File: rtl/cpm_fifo_sync.sv
// Synchronous FIFO with flop storage; a word written at cycle t is visible on
// rd_dat_o at t+1. Writes when full and reads when empty are dropped.
module cpm_fifo_sync #(
    parameter int DW    = 5,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_dat_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_dat_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;
    logic          wr_go;
    logic          rd_go;

    assign empty_o  = (wptr_q == rptr_q);
    assign full_o   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign wr_go    = wr_en_i && !full_o;
    assign rd_go    = rd_en_i && !empty_o;
    assign rd_dat_o = mem_q[rptr_q[AW-1:0]];

    // Storage is reset too so the read port shows zero until the first write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_go) begin
                mem_q[wptr_q[AW-1:0]] <= wr_dat_i;
                wptr_q                <= wptr_q + (AW+1)'(1);
            end
            if (rd_go) begin
                rptr_q <= rptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/eeg_fram_rd_agu.sv
// Per-lane sliding-window read AGU for the feature RAM (BASE + w*STRIDE + k), first address 1 cycle
// after config; outstanding reads are credit-limited to FIFO depth so returned data is never back-pressured.
module eeg_fram_rd_agu
    import eeg_agu_pkg::*;
#(
    parameter int ADD_AW     = 12,
    parameter int DAT_DW     = 4,
    parameter int CNT_DW     = 8,
    parameter int FIFO_DEPTH = AGU_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              is_idle_o,
    input  logic              cfg_vld_i,
    output logic              cfg_rdy_o,
    input  logic [ADD_AW-1:0] cfg_base_i,
    input  logic [CNT_DW-1:0] cfg_win_i,
    input  logic [CNT_DW-1:0] cfg_stride_i,
    input  logic [CNT_DW-1:0] cfg_nwin_i,
    output logic              add_vld_o,
    input  logic              add_rdy_i,
    output logic [ADD_AW-1:0] add_add_o,
    output logic              add_lst_o,
    output logic              add_end_o,
    input  logic              dat_vld_i,
    input  logic              dat_lst_i,
    input  logic [DAT_DW-1:0] dat_dat_i,
    output logic              dat_rdy_o,
    output logic              pe_vld_o,
    input  logic              pe_rdy_i,
    output logic              pe_lst_o,
    output logic [DAT_DW-1:0] pe_dat_o
);

    localparam int CRD_W = $clog2(FIFO_DEPTH) + 1;

    agu_state_e        state_q;
    logic [ADD_AW-1:0] wb_q;
    logic [ADD_AW-1:0] add_q;
    logic              lst_q;
    logic [CNT_DW-1:0] k_q;
    logic [CNT_DW-1:0] w_q;
    logic [CNT_DW-1:0] win_m1_q;
    logic [CNT_DW-1:0] nwin_m1_q;
    logic [CNT_DW-1:0] stride_q;
    logic [CRD_W-1:0]  credit_q;
    logic [CRD_W-1:0]  credit_d;
    logic              dat_rdy_q;

    logic              add_acc;
    logic              pe_pop;
    logic              last_beat;
    logic              k_wrap;
    logic [CNT_DW-1:0] k_d;
    logic [ADD_AW-1:0] wb_d;
    logic              fifo_empty;
    logic              fifo_full;

    assign is_idle_o = (state_q == AGU_IDLE);
    assign cfg_rdy_o = is_idle_o;
    assign add_vld_o = (state_q == AGU_RUN) && (credit_q < CRD_W'(FIFO_DEPTH));
    assign add_add_o = add_q;
    assign add_lst_o = lst_q;
    assign dat_rdy_o = dat_rdy_q;
    assign pe_vld_o  = !fifo_empty;

    assign add_acc   = add_vld_o && add_rdy_i;
    assign pe_pop    = pe_vld_o && pe_rdy_i;
    assign k_wrap    = (k_q == win_m1_q);
    assign last_beat = k_wrap && (w_q == nwin_m1_q);
    assign add_end_o = add_acc && last_beat;

    always_comb begin
        k_d  = k_q + CNT_DW'(1);
        wb_d = wb_q;
        if (k_wrap) begin
            k_d  = '0;
            wb_d = wb_q + ADD_AW'(stride_q);
        end
    end

    always_comb begin
        credit_d = credit_q;
        if (add_acc && !pe_pop) begin
            credit_d = credit_q + CRD_W'(1);
        end else if (!add_acc && pe_pop) begin
            credit_d = credit_q - CRD_W'(1);
        end
    end

    // Zero-length window or window count behaves as a single tap / single window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= AGU_IDLE;
            wb_q      <= '0;
            add_q     <= '0;
            lst_q     <= 1'b0;
            k_q       <= '0;
            w_q       <= '0;
            win_m1_q  <= '0;
            nwin_m1_q <= '0;
            stride_q  <= '0;
            credit_q  <= '0;
            dat_rdy_q <= 1'b0;
        end else begin
            credit_q  <= credit_d;
            dat_rdy_q <= 1'b1;
            case (state_q)
                AGU_IDLE: begin
                    if (cfg_vld_i) begin
                        state_q   <= AGU_RUN;
                        wb_q      <= cfg_base_i;
                        add_q     <= cfg_base_i;
                        k_q       <= '0;
                        w_q       <= '0;
                        stride_q  <= cfg_stride_i;
                        win_m1_q  <= (cfg_win_i == '0) ? '0 : cfg_win_i - CNT_DW'(1);
                        nwin_m1_q <= (cfg_nwin_i == '0) ? '0 : cfg_nwin_i - CNT_DW'(1);
                        lst_q     <= (cfg_win_i <= CNT_DW'(1));
                    end
                end
                AGU_RUN: begin
                    if (add_acc) begin
                        if (last_beat) begin
                            state_q <= AGU_DRAIN;
                            lst_q   <= 1'b0;
                        end else begin
                            k_q   <= k_d;
                            wb_q  <= wb_d;
                            add_q <= wb_d + ADD_AW'(k_d);
                            lst_q <= (k_d == win_m1_q);
                            if (k_wrap) begin
                                w_q <= w_q + CNT_DW'(1);
                            end
                        end
                    end
                end
                AGU_DRAIN: begin
                    // Leave as soon as the final pop retires the last credit.
                    if (credit_d == '0) begin
                        state_q <= AGU_IDLE;
                    end
                end
                default: state_q <= AGU_IDLE;
            endcase
        end
    end

    cpm_fifo_sync #(
        .DW    (DAT_DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_ret_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (dat_vld_i),
        .wr_dat_i ({dat_lst_i, dat_dat_i}),
        .rd_en_i  (pe_rdy_i),
        .rd_dat_o ({pe_lst_o, pe_dat_o}),
        .empty_o  (fifo_empty),
        .full_o   (fifo_full)
    );

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        dat_vld_i |-> !fifo_full);

    a_add_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (add_vld_o && !add_rdy_i) |=> ($stable(add_add_o) && $stable(add_lst_o)));

endmodule
